// File: rtl/bf_pkg.sv
// bf_pkg: constants and types shared by the Brainf*ck program loader, the
// program ROM/RAM and the execution core.
//   - 3-bit opcode encodings written into program memory
//   - loader FSM state enum
//   - source terminator bytes and a helper that recognises them
package bf_pkg;

  // Opcode encodings stored in program memory.
  localparam logic [2:0] OP_INC  = 3'b111;
  localparam logic [2:0] OP_DEC  = 3'b110;
  localparam logic [2:0] OP_MOVR = 3'b101;
  localparam logic [2:0] OP_MOVL = 3'b100;
  localparam logic [2:0] OP_IF   = 3'b011;
  localparam logic [2:0] OP_BACK = 3'b010;
  localparam logic [2:0] OP_OUT  = 3'b001;
  localparam logic [2:0] OP_NOP  = 3'b000;

  // Source bytes that end a program.
  localparam logic [7:0] TERM_NUL  = 8'h00;
  localparam logic [7:0] TERM_BANG = 8'h21;  // '!'

  // Loader states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } ld_state_e;

  function automatic logic is_term(input logic [7:0] ch);
    return (ch == TERM_NUL) || (ch == TERM_BANG);
  endfunction

endpackage

// File: rtl/bf_encoder.sv
// bf_encoder: combinational ASCII-to-opcode mapping.
// Ports:
//   ch    in  8  ASCII source byte
//   code  out 3  opcode for ch (OP_NOP when ch is not an opcode character)
//   is_op out 1  ch is one of the eight opcode characters
module bf_encoder
  import bf_pkg::*;
(
  input  logic [7:0] ch,
  output logic [2:0] code,
  output logic       is_op
);

  always_comb begin
    code  = OP_NOP;
    is_op = 1'b1;
    unique case (ch)
      8'h2B:   code = OP_INC;   // '+'
      8'h2D:   code = OP_DEC;   // '-'
      8'h3E:   code = OP_MOVR;  // '>'
      8'h3C:   code = OP_MOVL;  // '<'
      8'h5B:   code = OP_IF;    // '['
      8'h5D:   code = OP_BACK;  // ']'
      8'h2E:   code = OP_OUT;   // '.'
      8'h2C:   code = OP_NOP;   // ','
      default: is_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// bf_program_loader: streams ASCII Brainf*ck source into program memory.
// Opcode characters are encoded and written one cycle after acceptance,
// comments are consumed silently, and a NUL or '!' byte ends the load.
// Bracket nesting and program capacity are checked while loading.
// Ports:
//   clk          in   1         clock, rising edge
//   rst          in   1         synchronous active-high reset
//   load_start   in   1         pulse: begin (or restart) a load
//   in_valid     in   1         source byte valid
//   in_data      in   8         ASCII source byte
//   in_ready     out  1         byte accepted this cycle when in_valid is high
//   wr_en        out  1         program memory write strobe
//   wr_addr      out  ADDR_W    program memory write address
//   wr_code      out  3         opcode being written
//   prog_len     out  ADDR_W+1  opcodes stored by the last load
//   done         out  1         load finished cleanly
//   err_overflow out  1         program larger than 2**ADDR_W opcodes
//   err_bracket  out  1         unmatched '[' or ']'
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_code,
  output logic [ADDR_W:0]   prog_len,
  output logic              done,
  output logic              err_overflow,
  output logic              err_bracket
);

  // Full-program length: prog_len may reach this value but never exceed it.
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e         state_p0;
  ld_state_e         state_nx;
  logic [ADDR_W:0]   depth_p0;
  logic [ADDR_W:0]   len_p0;

  logic [2:0]        code_p0;
  logic              is_op_p0;
  logic              accept_p0;

  logic              do_clear;
  logic              do_wr;
  logic              depth_up;
  logic              depth_dn;
  logic              set_done;
  logic              set_ovf;
  logic              set_brk;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        code_p1;
  logic              done_p1;
  logic              ovf_p1;
  logic              brk_p1;

  bf_encoder u_encoder (
    .ch    (in_data),
    .code  (code_p0),
    .is_op (is_op_p0)
  );

  // A restart pulse takes priority over the byte offered in the same cycle,
  // so the byte is refused rather than silently dropped.
  assign in_ready  = (state_p0 == ST_LOAD) && !load_start && !rst;
  assign accept_p0 = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= ST_IDLE;
    else     state_p0 <= state_nx;
  end

  always_comb begin
    state_nx = state_p0;
    do_clear = 1'b0;
    do_wr    = 1'b0;
    depth_up = 1'b0;
    depth_dn = 1'b0;
    set_done = 1'b0;
    set_ovf  = 1'b0;
    set_brk  = 1'b0;
    if (load_start) begin
      state_nx = ST_LOAD;
      do_clear = 1'b1;
    end else if (accept_p0) begin
      if (is_term(in_data)) begin
        if (depth_p0 == '0) begin
          state_nx = ST_DONE;
          set_done = 1'b1;
        end else begin
          state_nx = ST_ERROR;
          set_brk  = 1'b1;
        end
      end else if (is_op_p0) begin
        if (len_p0 == CAPACITY) begin
          state_nx = ST_ERROR;
          set_ovf  = 1'b1;
        end else if ((code_p0 == OP_BACK) && (depth_p0 == '0)) begin
          state_nx = ST_ERROR;
          set_brk  = 1'b1;
        end else begin
          do_wr    = 1'b1;
          depth_up = (code_p0 == OP_IF);
          depth_dn = (code_p0 == OP_BACK);
        end
      end
    end
  end

  // ---- stage p0 -> p1: accepted opcode becomes a memory write ----
  // Depth never exceeds len_p0, so ADDR_W+1 bits cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      code_p1  <= OP_NOP;
      len_p0   <= '0;
      depth_p0 <= '0;
      done_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
      brk_p1   <= 1'b0;
    end else begin
      vld_p1 <= do_wr;
      if (do_clear) begin
        len_p0   <= '0;
        depth_p0 <= '0;
        done_p1  <= 1'b0;
        ovf_p1   <= 1'b0;
        brk_p1   <= 1'b0;
      end else begin
        if (do_wr) begin
          addr_p1 <= len_p0[ADDR_W-1:0];
          code_p1 <= code_p0;
          len_p0  <= len_p0 + 1'b1;
        end
        if (depth_up) depth_p0 <= depth_p0 + 1'b1;
        if (depth_dn) depth_p0 <= depth_p0 - 1'b1;
        if (set_done) done_p1 <= 1'b1;
        if (set_ovf)  ovf_p1  <= 1'b1;
        if (set_brk)  brk_p1  <= 1'b1;
      end
    end
  end

  // A write launched in the cycle before a reset is squashed while rst is high.
  assign wr_en        = vld_p1 && !rst;
  assign wr_addr      = addr_p1;
  assign wr_code      = code_p1;
  assign prog_len     = len_p0;
  assign done         = done_p1;
  assign err_overflow = ovf_p1;
  assign err_bracket  = brk_p1;

endmodule

// File: tb/tb_bf_program_loader.sv
module tb_bf_program_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_code;
  logic [ADDR_W:0]   prog_len;
  logic              done;
  logic              err_overflow;
  logic              err_bracket;

  always #5 clk = ~clk;

  bf_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_code      (wr_code),
    .prog_len     (prog_len),
    .done         (done),
    .err_overflow (err_overflow),
    .err_bracket  (err_bracket)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: status 0 idle, 1 loading, 2 done, 3 error.
  int  m_st;
  int  m_len;
  int  m_depth;
  bit  m_wr;
  int  m_addr;
  int  m_code;
  bit  m_done;
  bit  m_ovf;
  bit  m_brk;

  byte src_q[$];
  int  wlog[$];
  // Position in this string is the opcode value of the character.
  string ops  = ",.][<>-+";
  string pool = "+-<>[].,xy #";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit exp_wr;
    exp_wr = m_wr && !rst;
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_addr));
      chk({tag, ".wr_code"}, 32'(wr_code), 32'(m_code));
    end
    chk({tag, ".prog_len"}, 32'(prog_len), 32'(m_len));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".err_overflow"}, 32'(err_overflow), 32'(m_ovf));
    chk({tag, ".err_bracket"}, 32'(err_bracket), 32'(m_brk));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'((m_st == 1) && !load_start && !rst));
    if (wr_en === 1'b1) wlog.push_back(int'(wr_code));
  endtask

  task automatic model_accept(input byte b);
    int c;
    c = -1;
    for (int i = 0; i < 8; i++) if (ops[i] == b) c = i;
    if (b == 8'h00 || b == 8'h21) begin
      if (m_depth == 0) begin m_st = 2; m_done = 1; end
      else begin m_st = 3; m_brk = 1; end
    end else if (c >= 0) begin
      if (m_len == CAP) begin
        m_st = 3; m_ovf = 1;
      end else if (c == 2 && m_depth == 0) begin
        m_st = 3; m_brk = 1;
      end else begin
        m_wr = 1; m_addr = m_len; m_code = c; m_len++;
        if (c == 3) m_depth++;
        if (c == 2) m_depth--;
      end
    end
  endtask

  task automatic model_clear();
    m_st = 1; m_len = 0; m_depth = 0; m_wr = 0;
    m_done = 0; m_ovf = 0; m_brk = 0;
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    in_valid   = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check_outputs("start");
    load_start = 1'b0;
    wlog.delete();
  endtask

  task automatic run_src(input bit rand_valid, input int budget);
    int idx;
    int cyc;
    bit v;
    idx = 0;
    cyc = 0;
    while (m_st == 1 && idx < src_q.size() && cyc < budget) begin
      v        = rand_valid ? ($urandom_range(0, 1) != 0) : 1'b1;
      in_valid = v;
      in_data  = src_q[idx];
      @(posedge clk);
      m_wr = 0;
      if (v) begin
        model_accept(src_q[idx]);
        idx++;
      end
      @(negedge clk);
      check_outputs("src");
      cyc++;
    end
    in_valid = 1'b0;
    src_q.delete();
    if (cyc >= budget) chk("cycle_budget", 32'(cyc), 32'(budget - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_wr = 0;
      @(negedge clk);
      check_outputs("idle");
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_start = 1'b1;
    #1;
    check_outputs("rst_cycle");
    @(posedge clk);
    m_st = 0; m_len = 0; m_depth = 0; m_wr = 0;
    m_done = 0; m_ovf = 0; m_brk = 0;
    @(negedge clk);
    check_outputs("rst_after");
    chk("rst.wr_addr", 32'(wr_addr), 32'd0);
    chk("rst.wr_code", 32'(wr_code), 32'd0);
    rst        = 1'b0;
    load_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    m_st = 0; m_len = 0; m_depth = 0; m_wr = 0; m_addr = 0; m_code = 0;
    m_done = 0; m_ovf = 0; m_brk = 0;
    @(negedge clk);
    do_reset();
    idle(1);

    // Nested loop program, NUL terminated
    start_load();
    add_str("++[>++[>++<-]<-]>>");
    src_q.push_back(8'h00);
    run_src(1'b0, 100);
    idle(2);
    chk("nest.prog_len", 32'(prog_len), 32'd18);
    chk("nest.done", 32'(done), 32'd1);
    chk("nest.nwrites", 32'(wlog.size()), 32'd18);
    if (wlog.size() == 18) begin
      chk("nest.code2", 32'(wlog[2]), 32'd3);
      chk("nest.code3", 32'(wlog[3]), 32'd5);
      chk("nest.code17", 32'(wlog[17]), 32'd5);
    end

    // Comments interleaved, '!' terminated
    start_load();
    add_str("+a b\n-!");
    run_src(1'b0, 100);
    idle(1);
    chk("cmt.prog_len", 32'(prog_len), 32'd2);
    chk("cmt.done", 32'(done), 32'd1);
    chk("cmt.nwrites", 32'(wlog.size()), 32'd2);

    // Stray ']'
    start_load();
    add_str("+]");
    run_src(1'b0, 100);
    idle(2);
    chk("close.err_bracket", 32'(err_bracket), 32'd1);
    chk("close.prog_len", 32'(prog_len), 32'd1);
    chk("close.nwrites", 32'(wlog.size()), 32'd1);

    // Unclosed '[' at the terminator
    start_load();
    add_str("[[+]");
    src_q.push_back(8'h00);
    run_src(1'b0, 100);
    idle(1);
    chk("open.err_bracket", 32'(err_bracket), 32'd1);
    chk("open.done", 32'(done), 32'd0);

    // Exactly full program
    start_load();
    for (int i = 0; i < CAP; i++) src_q.push_back("+");
    src_q.push_back(8'h00);
    run_src(1'b0, 400);
    idle(1);
    chk("full.done", 32'(done), 32'd1);
    chk("full.prog_len", 32'(prog_len), 32'(CAP));
    chk("full.nwrites", 32'(wlog.size()), 32'(CAP));

    // One opcode too many
    start_load();
    for (int i = 0; i < CAP + 1; i++) src_q.push_back("+");
    run_src(1'b0, 400);
    idle(2);
    chk("ovf.err_overflow", 32'(err_overflow), 32'd1);
    chk("ovf.prog_len", 32'(prog_len), 32'(CAP));
    chk("ovf.nwrites", 32'(wlog.size()), 32'(CAP));
    chk("ovf.done", 32'(done), 32'd0);

    // Random programs with random in_valid gaps
    for (int it = 0; it < 8; it++) begin
      int n;
      start_load();
      n = int'($urandom_range(10, 40));
      for (int i = 0; i < n; i++) src_q.push_back(pool[int'($urandom_range(0, pool.len() - 1))]);
      src_q.push_back(8'h00);
      run_src(1'b1, 1000);
      idle(1);
      chk("rnd.nwrites", 32'(wlog.size()), 32'(m_len));
    end

    // Restart while loading: the byte offered with load_start is refused
    start_load();
    add_str("++");
    run_src(1'b0, 20);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = "+";
    #1;
    chk("restart.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check_outputs("restart");
    load_start = 1'b0;
    in_valid   = 1'b0;
    wlog.delete();
    add_str("-");
    src_q.push_back(8'h00);
    run_src(1'b0, 20);
    idle(1);
    chk("restart.prog_len", 32'(prog_len), 32'd1);
    chk("restart.done", 32'(done), 32'd1);

    // Reset in the middle of a load, with a write in flight
    start_load();
    add_str("+++");
    run_src(1'b0, 20);
    do_reset();
    idle(1);
    start_load();
    add_str("-");
    src_q.push_back(8'h00);
    run_src(1'b0, 20);
    idle(1);
    chk("post_rst.prog_len", 32'(prog_len), 32'd1);
    chk("post_rst.nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("post_rst.code", 32'(wlog[0]), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
